// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the round-robin / fixed-priority channel multiplexer.
package rr_mux_arb_pkg;

    // Arbitration mode encodings for the MODE parameter.
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Ceiling log2, used to size channel-index fields (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_mux_arb_arbiter.sv
// One-hot arbiter: grants the first requester found searching upward from a
// start index (ptr in round-robin mode, 0 in fixed-priority mode), wrapping.
module rr_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [NCH-1:0]  grant
);

    // Distance travelled upward (with wrap) from origin to reach idx.
    function automatic int ring_dist(input int idx, input int origin);
        int d;
        d = idx - origin;
        if (d < 0) begin
            d = d + NCH;
        end
        return d;
    endfunction

    // Pick the requester closest to the start point; ties are impossible
    // because every channel has a distinct distance.
    always_comb begin
        int start;
        int best;
        start = mode ? 0 : int'(ptr);
        best  = NCH;
        for (int i = 0; i < NCH; i++) begin
            if (req[i] && (ring_dist(i, start) < best)) begin
                best = ring_dist(i, start);
            end
        end
        grant = '0;
        for (int i = 0; i < NCH; i++) begin
            grant[i] = req[i] && (ring_dist(i, start) == best);
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel to one arbitrated multiplexer with a single registered output
// slot. A word is accepted whenever the slot is empty or being drained, so a
// continuously ready sink sees one word per cycle.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  NCH   = 4,
    parameter int  MODE  = MODE_RR,
    localparam int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    localparam logic FIXED_PRIO = (MODE == MODE_FIXED);

    logic [WIDTH-1:0] data_p1;
    logic [SELW-1:0]  sel_p1;
    logic             vld_p1;
    logic [SELW-1:0]  ptr;

    logic             load_en;
    logic             xfer;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  grant_idx;
    logic [SELW-1:0]  ptr_next;
    logic [WIDTH-1:0] mux_data;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arbiter (
        .req   (in_valid),
        .ptr   (ptr),
        .mode  (FIXED_PRIO),
        .grant (grant)
    );

    // The slot can take a new word when empty or when its word leaves now.
    assign load_en  = !vld_p1 || out_ready;
    assign in_ready = reset ? '0 : (grant & {NCH{load_en}});
    assign xfer     = |(in_valid & in_ready);

    // Encode the one-hot grant into a channel index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                grant_idx = SELW'(i);
            end
        end
    end

    // Round-robin pointer moves to the channel after the winner, wrapping.
    always_comb begin
        if (grant_idx == SELW'(NCH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end
    end

    assign mux_data = in_data[grant_idx*WIDTH +: WIDTH];

    // Stage p1: output slot and arbitration pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= mux_data;
            sel_p1  <= grant_idx;
            if (!FIXED_PRIO) begin
                ptr <= ptr_next;
            end
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: one round-robin and one fixed-priority instance.
module tb_rr_mux_arb;

    logic        clk;
    logic        reset;

    logic [31:0] rr_in_data;
    logic [3:0]  rr_in_valid;
    logic [3:0]  rr_in_ready;
    logic [7:0]  rr_out_data;
    logic        rr_out_valid;
    logic        rr_out_ready;
    logic [1:0]  rr_out_sel;

    logic [31:0] fx_in_data;
    logic [3:0]  fx_in_valid;
    logic [3:0]  fx_in_ready;
    logic [7:0]  fx_out_data;
    logic        fx_out_valid;
    logic        fx_out_ready;
    logic [1:0]  fx_out_sel;

    int checks;
    int failures;

    rr_mux_arb #(.WIDTH(8), .NCH(4), .MODE(0)) dut_rr (
        .clk       (clk),
        .reset     (reset),
        .in_data   (rr_in_data),
        .in_valid  (rr_in_valid),
        .in_ready  (rr_in_ready),
        .out_data  (rr_out_data),
        .out_valid (rr_out_valid),
        .out_ready (rr_out_ready),
        .out_sel   (rr_out_sel)
    );

    rr_mux_arb #(.WIDTH(8), .NCH(4), .MODE(1)) dut_fx (
        .clk       (clk),
        .reset     (reset),
        .in_data   (fx_in_data),
        .in_valid  (fx_in_valid),
        .in_ready  (fx_in_ready),
        .out_data  (fx_out_data),
        .out_valid (fx_out_valid),
        .out_ready (fx_out_ready),
        .out_sel   (fx_out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rr_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
        check_eq({tag, "_valid"}, 32'(rr_out_valid), 32'(v));
        check_eq({tag, "_sel"},   32'(rr_out_sel),   32'(s));
        check_eq({tag, "_data"},  32'(rr_out_data),  32'(d));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        rr_in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        rr_in_valid  = 4'b1111;
        rr_out_ready = 1'b1;
        fx_in_data   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        fx_in_valid  = 4'b0000;
        fx_out_ready = 1'b1;
        #2;

        // Reset held 3 cycles with every channel requesting.
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_in_ready", 32'(rr_in_ready), 32'h0);
            tick();
        end
        reset = 1'b0;
        check_rr_out("after_rst", 1'b0, 2'd0, 8'h00);
        check_eq("fx_after_rst_valid", 32'(fx_out_valid), 32'h0);
        #1;
        check_eq("first_grant", 32'(rr_in_ready), 32'b0001);

        // Round-robin fairness: 0,1,2,3,0,1.
        for (int k = 0; k < 6; k++) begin
            tick();
            check_rr_out("rr_seq", 1'b1, 2'(k % 4), 8'hA0 + 8'(k % 4));
        end

        // Backpressure: slot holds channel 1, ptr stays at 2.
        rr_in_valid  = 4'b0110;
        rr_out_ready = 1'b0;
        #1;
        check_eq("bp_in_ready0", 32'(rr_in_ready), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_rr_out("bp_hold", 1'b1, 2'd1, 8'hA1);
            check_eq("bp_in_ready", 32'(rr_in_ready), 32'h0);
        end
        rr_out_ready = 1'b1;
        #1;
        check_eq("bp_release_grant", 32'(rr_in_ready), 32'b0100);
        tick();
        check_rr_out("bp_release", 1'b1, 2'd2, 8'hA2);

        // Sparse / wrap: ptr=3, only channel 0 then only channel 3.
        rr_in_valid = 4'b0001;
        #1;
        check_eq("wrap_grant0", 32'(rr_in_ready), 32'b0001);
        tick();
        check_rr_out("wrap_ch0", 1'b1, 2'd0, 8'hA0);
        rr_in_valid = 4'b1000;
        #1;
        check_eq("wrap_grant3", 32'(rr_in_ready), 32'b1000);
        tick();
        check_rr_out("wrap_ch3", 1'b1, 2'd3, 8'hA3);
        rr_in_valid = 4'b1111;
        #1;
        check_eq("wrap_ptr0", 32'(rr_in_ready), 32'b0001);
        tick();
        check_rr_out("wrap_after", 1'b1, 2'd0, 8'hA0);

        // Drain with no transfer: valid clears, data/sel hold, ptr stays 1.
        rr_in_valid = 4'b0000;
        #1;
        check_eq("drain_in_ready", 32'(rr_in_ready), 32'h0);
        tick();
        check_rr_out("drain", 1'b0, 2'd0, 8'hA0);
        rr_in_valid = 4'b1111;
        rr_in_data  = {8'hA3, 8'hA2, 8'h55, 8'hA0};
        #1;
        check_eq("drain_ptr1", 32'(rr_in_ready), 32'b0010);
        tick();
        check_rr_out("load55", 1'b1, 2'd1, 8'h55);

        // Reset mid-stream with the sink stalled: held 0x55 is discarded.
        reset        = 1'b1;
        rr_out_ready = 1'b0;
        #1;
        check_eq("midrst_in_ready", 32'(rr_in_ready), 32'h0);
        tick();
        reset       = 1'b0;
        rr_in_valid = 4'b0000;
        check_rr_out("midrst", 1'b0, 2'd0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("midrst_valid", 32'(rr_out_valid), 32'h0);
            check_eq("midrst_data", 32'(rr_out_data), 32'h0);
        end
        rr_in_valid  = 4'b1111;
        rr_out_ready = 1'b1;
        #1;
        check_eq("postrst_grant0", 32'(rr_in_ready), 32'b0001);
        tick();
        check_rr_out("postrst", 1'b1, 2'd0, 8'hA0);

        // Fixed priority: channel 1 always beats channel 3.
        fx_in_valid = 4'b1010;
        #1;
        check_eq("fx_grant", 32'(fx_in_ready), 32'b0010);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("fx_sel", 32'(fx_out_sel), 32'd1);
            check_eq("fx_data", 32'(fx_out_data), 32'hB1);
            check_eq("fx_valid", 32'(fx_out_valid), 32'h1);
            check_eq("fx_in_ready", 32'(fx_in_ready), 32'b0010);
        end
        fx_in_valid = 4'b1100;
        #1;
        check_eq("fx_grant2", 32'(fx_in_ready), 32'b0100);
        tick();
        check_eq("fx_sel2", 32'(fx_out_sel), 32'd2);
        check_eq("fx_data2", 32'(fx_out_data), 32'hB2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, legal range 1..32.
REQ-002 Parameter NCH, default 4: number of input channels, legal range 2..8.
REQ-003 Parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-004 Derived constant SELW = clog2(NCH): channel-index width.
REQ-005 One clock; reset is synchronous and active-high; the ports are named clk and reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NCH  per-channel request.
REQ-010 in_ready  output  NCH  per-channel accept; combinational.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data/out_sel hold a word.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_sel  output  SELW  index of the channel that supplied out_data.

Function
REQ-015 load_en SHALL equal (!out_valid | out_ready).
REQ-016 Exactly one channel SHALL be granted per cycle when any in_valid bit is set; no channel SHALL be granted otherwise.
REQ-017 In MODE 0, the grant SHALL go to the first valid channel searching upward from ptr, wrapping from NCH-1 to 0.
REQ-018 In MODE 1, the grant SHALL go to the lowest-index valid channel, and ptr SHALL be unused.
REQ-019 in_ready[i] SHALL be grant[i] & load_en, which makes at most one bit high.
REQ-020 A transfer SHALL occur on channel i when in_valid[i] & in_ready[i].
REQ-021 On a transfer, the next edge SHALL load out_data, set out_sel=i and set out_valid=1, giving a latency of 1 cycle.
REQ-022 On a transfer in MODE 0, ptr SHALL become (i+1) mod NCH, including the wrap from NCH-1 to 0.
REQ-023 When out_valid & out_ready and there is no transfer, out_valid SHALL clear and out_data/out_sel SHALL hold their values.
REQ-024 A simultaneous drain and transfer SHALL reload the register with out_valid staying 1, sustaining one word per cycle.
REQ-025 When out_valid & !out_ready, all in_ready bits SHALL be 0 and out_data, out_sel and ptr SHALL hold.
REQ-026 in_valid asserted for a non-granted channel SHALL have no effect on state.
REQ-027 ptr SHALL change only on a transfer.

Reset
REQ-028 While reset=1, out_valid SHALL be 0, out_data SHALL be 0, out_sel SHALL be 0 and ptr SHALL be 0 at the next edge.
REQ-029 While reset=1, in_ready SHALL be all 0, overriding load_en.
REQ-030 Reset asserted mid-stream SHALL discard any held word, which is never presented after reset.
REQ-031 The first arbitration after reset release SHALL start from channel 0.

Structure
REQ-032 The clog2 function and the MODE encodings (MODE_RR=0, MODE_FIXED=1) SHALL live in the shared project package/header.
REQ-033 The arbitration logic SHALL be a sub-module rr_arbiter (inputs req, ptr, mode; output one-hot grant), instantiated once.
REQ-034 The datapath mux SHALL be an indexed part-select on in_data using the encoded grant.

Verification
REQ-035 Reset scenario: NCH=4, all in_valid=1, reset held 3 cycles -> in_ready=0000 throughout, and out_valid=0, out_data=0x00, out_sel=0 after reset.
REQ-036 Round-robin fairness scenario: MODE 0, NCH=4, in_valid=1111, data i = 0xA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles with out_data 0xA0,0xA1,0xA2,0xA3,0xA0,0xA1.
REQ-037 Backpressure scenario: out_ready=0 for 4 cycles with in_valid=0110 -> out_valid stays 1, out_sel stays 1, in_ready=0000, ptr unchanged; on release, out_sel goes to 2 on the next cycle.
REQ-038 Sparse/wrap scenario: MODE 0, ptr=3, in_valid=0001 -> grant on channel 0, ptr becomes 1; then with in_valid=1000, grant on channel 3 and ptr wraps to 0.
REQ-039 Fixed-priority scenario: MODE 1, in_valid=1010 held -> out_sel=1 every cycle and channel 3 is never granted.
REQ-040 Reset mid-stream scenario: out_valid=1 with out_data=0x55, reset pulsed for 1 cycle with out_ready=0 -> out_valid=0 next cycle and 0x55 is never seen after reset.
